// File: rtl/gb_line_clear_ctrl_if.sv
// Remove-line instruction bus from the line-clear sequencer to the board memory.
// Ports: instr_out[31:0], instr_valid; master = sequencer, slave = CPU mux / memory.
interface gb_line_clear_ctrl_if;
  logic [31:0] instr_out;
  logic        instr_valid;

  modport master (
    output instr_out,
    output instr_valid
  );

  modport slave (
    input instr_out,
    input instr_valid
  );
endinterface

// File: rtl/gb_line_clear_ctrl.sv
// Line-clear sequencer: scans full-row flags bottom-up and issues remove-line ops.
// Ports: clk, rst_n, start, line_status_in, score_clr, ibus, busy, done, lines_cleared, score.
module gb_line_clear_ctrl #(
  parameter int         NUM_ROWS  = 20,
  parameter int         MAX_CLEAR = 4,
  parameter logic [5:0] OPC_RM    = 6'b011101
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NUM_ROWS-1:0]   line_status_in,
  input  logic                  score_clr,
  gb_line_clear_ctrl_if.master  ibus,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            lines_cleared,
  output logic [15:0]           score
);

  localparam int            IW   = $clog2(NUM_ROWS);
  localparam logic [IW-1:0] LAST = IW'(NUM_ROWS - 1);
  localparam logic [2:0]    MAXC = 3'(MAX_CLEAR);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    ISSUE,
    SETTLE,
    FIN
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [IW-1:0] idx;
  logic [2:0]    count;
  logic [15:0]   score_r;
  logic [3:0]    inc;
  logic [16:0]   sum;
  logic          row_full;

  assign row_full = line_status_in[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (start) state_n = SCAN;
      SCAN: begin
        if (row_full)         state_n = ISSUE;
        else if (idx == LAST) state_n = FIN;
      end
      ISSUE:  state_n = (count + 3'd1 == MAXC) ? FIN : SETTLE;
      SETTLE: state_n = SCAN;
      FIN:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // idx is held across ISSUE/SETTLE: rows above shift down into it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx           <= '0;
      count         <= '0;
      lines_cleared <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            idx           <= '0;
            count         <= '0;
            lines_cleared <= '0;
          end
        end
        SCAN: begin
          if (!row_full && idx != LAST) idx <= idx + 1'b1;
        end
        ISSUE: count <= count + 3'd1;
        FIN:   lines_cleared <= count;
        default: ;
      endcase
    end
  end

  always_comb begin
    inc = 4'd0;
    unique case (count)
      3'd1:    inc = 4'd1;
      3'd2:    inc = 4'd3;
      3'd3:    inc = 4'd5;
      3'd4:    inc = 4'd8;
      default: inc = 4'd0;
    endcase
  end

  assign sum = {1'b0, score_r} + {13'b0, inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          score_r <= '0;
    else if (score_clr)  score_r <= '0;
    else if (state == FIN)
      score_r <= sum[16] ? 16'hFFFF : sum[15:0];
  end

  assign score = score_r;
  assign busy  = (state != IDLE);
  assign done  = (state == FIN);

  assign ibus.instr_valid = (state == ISSUE);
  assign ibus.instr_out   = (state == ISSUE) ?
                            {OPC_RM, 10'b0, 16'(idx)} : 32'h0;

endmodule

// File: tb/tb_gb_line_clear_ctrl.sv
// Testbench for gb_line_clear_ctrl: board-memory model plus timeline reference.
// Drives random and directed boards; checks pulses, timing, lines_cleared, score.
module tb_gb_line_clear_ctrl;

  localparam logic [5:0] OPC = 6'b011101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        score_clr;
  logic        busy;
  logic        done;
  logic [2:0]  lines_cleared;
  logic [15:0] score;

  logic [19:0] board;
  logic [19:0] board_init;
  logic        load;
  logic        sticky;

  gb_line_clear_ctrl_if bus();

  gb_line_clear_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .line_status_in (board),
    .score_clr      (score_clr),
    .ibus           (bus),
    .busy           (busy),
    .done           (done),
    .lines_cleared  (lines_cleared),
    .score          (score)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int exp_score = 0;
  int inc_tab[5] = '{0, 1, 3, 5, 8};

  int          exp_cyc[$];
  logic [31:0] exp_word[$];
  int          exp_done;
  int          exp_n;

  int          obs_cyc[$];
  logic [31:0] obs_word[$];
  int          done_cnt;
  int          idle_bad;

  function automatic logic [19:0] rm_row(input logic [19:0] b, input int i);
    logic [19:0] lowmask;
    lowmask = (20'd1 << i) - 20'd1;
    return (b & lowmask) | ((b >> (i + 1)) << i);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Board memory: removing row i shifts every row above it down by one
  always @(posedge clk) begin
    if (load)
      board <= board_init;
    else if (bus.instr_valid && !sticky)
      board <= rm_row(board, int'(bus.instr_out[4:0]));
  end

  always @(negedge clk) begin
    if (bus.instr_valid) begin
      obs_cyc.push_back(cyc);
      obs_word.push_back(bus.instr_out);
    end else if (bus.instr_out !== 32'h0) begin
      idle_bad++;
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Timeline reference: start seen in cycle t0, first row examined in t0+1
  task automatic model(input logic [19:0] b0, input bit stk, input int t0);
    logic [19:0] b;
    int idx;
    int n;
    int t;
    b = b0;
    idx = 0;
    n = 0;
    t = t0 + 1;
    exp_cyc.delete();
    exp_word.delete();
    forever begin
      if (b[idx]) begin
        exp_cyc.push_back(t + 1);
        exp_word.push_back({OPC, 10'b0, 16'(idx)});
        n++;
        if (!stk) b = rm_row(b, idx);
        if (n == 4) begin
          exp_done = t + 2;
          break;
        end
        t += 3;
      end else if (idx == 19) begin
        exp_done = t + 1;
        break;
      end else begin
        idx++;
        t++;
      end
    end
    exp_n = n;
  endtask

  task automatic run(input logic [19:0] b, input bit stk, input bit clr_fin,
                     input int poke, input string tag);
    int t0;
    int k;
    int m;
    obs_cyc.delete();
    obs_word.delete();
    done_cnt = 0;
    idle_bad = 0;
    board_init = b;
    sticky = stk;
    load = 1'b1;
    start = 1'b1;
    t0 = cyc;
    model(b, stk, t0);
    @(negedge clk);
    load = 1'b0;
    start = 1'b0;
    k = 1;
    chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
    while (done !== 1'b1 && k < 200) begin
      if (k == poke) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    chk({tag, "_done_cycle"}, 32'(cyc - t0), 32'(exp_done - t0));
    chk({tag, "_lc_in_fin"}, 32'(lines_cleared), 32'd0);
    if (clr_fin) score_clr = 1'b1;
    @(negedge clk);
    score_clr = 1'b0;
    if (clr_fin) exp_score = 0;
    else begin
      exp_score = exp_score + inc_tab[exp_n];
      if (exp_score > 65535) exp_score = 65535;
    end
    chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    chk({tag, "_lines"}, 32'(lines_cleared), 32'(exp_n));
    chk({tag, "_score"}, 32'(score), 32'(exp_score));
    chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    chk({tag, "_idle_word"}, 32'(idle_bad), 32'd0);
    chk({tag, "_n_pulses"}, 32'(obs_cyc.size()), 32'(exp_n));
    m = (obs_cyc.size() < exp_n) ? obs_cyc.size() : exp_n;
    for (int i = 0; i < m; i++) begin
      chk({tag, "_pulse_cyc"}, 32'(obs_cyc[i] - t0), 32'(exp_cyc[i] - t0));
      chk({tag, "_pulse_word"}, obs_word[i], exp_word[i]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [19:0] rb;
    rst_n = 1'b0;
    start = 1'b0;
    score_clr = 1'b0;
    load = 1'b1;
    board_init = 20'h0;
    sticky = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_word", bus.instr_out, 32'h0);
    chk("rst_lines", 32'(lines_cleared), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    rst_n = 1'b1;
    load = 1'b0;
    @(negedge clk);

    run(20'h00000, 1'b0, 1'b0, 0, "empty");
    run(20'h00001, 1'b0, 1'b0, 0, "row0");
    run(20'h00018, 1'b0, 1'b0, 0, "rows34");
    run(20'hFFFFF, 1'b1, 1'b0, 0, "all");
    run(20'h80000, 1'b0, 1'b0, 0, "top");
    run(20'h80000, 1'b1, 1'b0, 0, "top_stuck");
    run(20'h00007, 1'b0, 1'b0, 0, "three");

    for (int i = 0; i < 12; i++) begin
      rb = 20'($urandom) & 20'($urandom);
      run(rb, ($urandom_range(3) == 0), 1'b0, 0, "rand");
    end

    force dut.score_r = 16'hFFFC;
    @(negedge clk);
    release dut.score_r;
    exp_score = 32'hFFFC;
    @(negedge clk);
    chk("preload", 32'(score), 32'(exp_score));
    run(20'hFFFFF, 1'b1, 1'b0, 0, "sat");
    run(20'hFFFFF, 1'b1, 1'b1, 0, "clr_fin");
    run(20'h00011, 1'b0, 1'b0, 0, "pre_rst");

    board_init = 20'hFFFFF;
    sticky = 1'b1;
    load = 1'b1;
    start = 1'b1;
    @(negedge clk);
    load = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("abort_issue", 32'(bus.instr_valid), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_score = 0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_valid", 32'(bus.instr_valid), 32'd0);
    chk("abort_word", bus.instr_out, 32'h0);
    chk("abort_lines", 32'(lines_cleared), 32'd0);
    chk("abort_score", 32'(score), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rb = 20'($urandom) & 20'($urandom) | 20'h00004;
    run(rb, 1'b0, 1'b0, 3, "post_rst");
    run(20'h00100, 1'b0, 1'b0, 10, "restart_ign");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
